// File: rtl/mmio_timer_periph.sv
// mmio_timer_periph: memory-mapped responder for the CPU data bus.
// Owns the timer (TH/TL/TCON), LED, seven-segment and SYSTICK registers.
// Reads are combinational; writes land on the rising edge where mem_write && hit.
//
// Optional feature: define MMIO_SYSTICK_EN to build the free-running SYSTICK counter
// at offset 0x14. When the macro is undefined, 0x14 reads 0 and writes are ignored.
//
// Ports:
//   clk       in   sole clock, rising edge
//   reset     in   asynchronous, active-low
//   addr      in   byte address from the MEM stage, bits [1:0] ignored
//   wdata     in   store data
//   mem_read  in   load strobe (rdata is valid whenever hit, so it is not needed)
//   mem_write in   store strobe
//   rdata     out  combinational load data, 0 outside the window
//   hit       out  addr lies in BASE_ADDR .. BASE_ADDR+0x1F
//   led       out  LED register
//   digi      out  seven-segment register
//   irq       out  level timer interrupt, TCON[1] & TCON[2]
module mmio_timer_periph #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int unsigned TICK_DIV  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic [31:0] rdata,
    output logic        hit,
    output logic [7:0]  led,
    output logic [11:0] digi,
    output logic        irq
);

    localparam logic [2:0]  OffTh   = 3'd0;
    localparam logic [2:0]  OffTl   = 3'd1;
    localparam logic [2:0]  OffTcon = 3'd2;
    localparam logic [2:0]  OffLed  = 3'd3;
    localparam logic [2:0]  OffDigi = 3'd4;
    localparam logic [2:0]  OffSys  = 3'd5;
    localparam logic [15:0] PrescLast = 16'(TICK_DIV - 1);

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic [2:0]  tcon_q, tcon_d;
    logic [7:0]  led_q, led_d;
    logic [11:0] digi_q, digi_d;
    logic [15:0] presc_q, presc_d;
    logic [31:0] systick_rd;

    logic [2:0] off;
    logic       wr;
    logic       tick;
    logic       ovf;

    // Byte lanes and the load strobe carry no information for this block.
    logic unused_bits;
    assign unused_bits = ^{addr[1:0], mem_read};

    assign off  = addr[4:2];
    assign hit  = (addr[31:5] == BASE_ADDR[31:5]);
    assign wr   = mem_write & hit;
    assign tick = tcon_q[0] && (presc_q == PrescLast);
    // A CPU write to TL swallows the tick, so it cannot overflow either.
    assign ovf  = tick && (tl_q == 32'hFFFF_FFFF) && !(wr && off == OffTl);

    always_comb begin
        presc_d = 16'd0;
        if (tcon_q[0] && !tick) begin
            presc_d = presc_q + 16'd1;
        end

        th_d = th_q;
        if (wr && off == OffTh) begin
            th_d = wdata;
        end

        tl_d = tl_q;
        if (wr && off == OffTl) begin
            tl_d = wdata;
        end else if (tick) begin
            // Reload uses the old TH even if TH is being written this cycle.
            tl_d = (tl_q == 32'hFFFF_FFFF) ? th_q : tl_q + 32'd1;
        end

        tcon_d = tcon_q;
        if (wr && off == OffTcon) begin
            tcon_d[1:0] = wdata[1:0];
            if (wdata[2]) begin
                tcon_d[2] = 1'b0;
            end
        end
        // Overflow set beats a same-cycle write-1-to-clear.
        if (ovf && tcon_q[1]) begin
            tcon_d[2] = 1'b1;
        end

        led_d  = (wr && off == OffLed) ? wdata[7:0] : led_q;
        digi_d = (wr && off == OffDigi) ? wdata[11:0] : digi_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th_q    <= '0;
            tl_q    <= '0;
            tcon_q  <= '0;
            led_q   <= '0;
            digi_q  <= '0;
            presc_q <= '0;
        end else begin
            th_q    <= th_d;
            tl_q    <= tl_d;
            tcon_q  <= tcon_d;
            led_q   <= led_d;
            digi_q  <= digi_d;
            presc_q <= presc_d;
        end
    end

`ifdef MMIO_SYSTICK_EN
    logic [31:0] systick_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            systick_q <= '0;
        end else if (wr && off == OffSys) begin
            systick_q <= '0;
        end else begin
            systick_q <= systick_q + 32'd1;
        end
    end

    assign systick_rd = systick_q;
`else
    assign systick_rd = '0;
`endif

    always_comb begin
        rdata = '0;
        if (hit) begin
            case (off)
                OffTh:   rdata = th_q;
                OffTl:   rdata = tl_q;
                OffTcon: rdata = {29'd0, tcon_q};
                OffLed:  rdata = {24'd0, led_q};
                OffDigi: rdata = {20'd0, digi_q};
                OffSys:  rdata = systick_rd;
                default: rdata = '0;
            endcase
        end
    end

    assign led  = led_q;
    assign digi = digi_q;
    assign irq  = tcon_q[1] & tcon_q[2];

endmodule

// File: tb/tb_mmio_timer_periph.sv
// Bench for mmio_timer_periph: two instances (TICK_DIV=1 and TICK_DIV=4) share one bus
// and are each tracked by a cycle-level behavioural model of the register map.
module tb_mmio_timer_periph;

    localparam logic [31:0] Base = 32'h4000_0000;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] rdata1, rdata4;
    logic        hit1, hit4;
    logic [7:0]  led1, led4;
    logic [11:0] digi1, digi4;
    logic        irq1, irq4;

    mmio_timer_periph #(.BASE_ADDR(Base), .TICK_DIV(1)) dut1 (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .mem_read(mem_read),
        .mem_write(mem_write), .rdata(rdata1), .hit(hit1), .led(led1), .digi(digi1),
        .irq(irq1)
    );

    mmio_timer_periph #(.BASE_ADDR(Base), .TICK_DIV(4)) dut4 (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .mem_read(mem_read),
        .mem_write(mem_write), .rdata(rdata4), .hit(hit4), .led(led4), .digi(digi4),
        .irq(irq4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model, index 0 -> dut1, index 1 -> dut4.
    int          divs[2] = '{1, 4};
    int          m_pre[2];
    logic [31:0] m_th[2];
    logic [31:0] m_tl[2];
    logic [2:0]  m_tcon[2];
    logic [7:0]  m_led[2];
    logic [11:0] m_digi[2];
    logic [31:0] m_sys[2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pre[i] = 0; m_th[i] = '0; m_tl[i] = '0; m_tcon[i] = '0;
            m_led[i] = '0; m_digi[i] = '0; m_sys[i] = '0;
        end
    endtask

    function automatic logic m_hit(logic [31:0] a);
        return a[31:5] == Base[31:5];
    endfunction

    function automatic logic [31:0] m_rdata(int i, logic [31:0] a);
        if (!m_hit(a)) return 32'd0;
        case (a[4:2])
            3'd0: return m_th[i];
            3'd1: return m_tl[i];
            3'd2: return {29'd0, m_tcon[i]};
            3'd3: return {24'd0, m_led[i]};
            3'd4: return {20'd0, m_digi[i]};
`ifdef MMIO_SYSTICK_EN
            3'd5: return m_sys[i];
`endif
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_irq(int i);
        return m_tcon[i][1] & m_tcon[i][2];
    endfunction

    // Advance the model over one rising edge using the inputs currently on the bus.
    task automatic model_edge();
        logic       w;
        logic [2:0] o;
        logic       tick;
        logic       ovf;
        logic [31:0] n_tl;
        logic [2:0]  n_tcon;
        if (!reset) begin
            model_reset();
            return;
        end
        w = mem_write && m_hit(addr);
        o = addr[4:2];
        for (int i = 0; i < 2; i++) begin
            // Tick fires on every divs[i]-th enabled cycle.
            tick = m_tcon[i][0] && (((m_pre[i] + 1) % divs[i]) == 0);
            m_pre[i] = m_tcon[i][0] ? (m_pre[i] + 1) % divs[i] : 0;
            ovf = 1'b0;
            n_tl = m_tl[i];
            if (w && o == 3'd1) begin
                n_tl = wdata;
            end else if (tick) begin
                if (m_tl[i] == 32'hFFFF_FFFF) begin
                    n_tl = m_th[i];
                    ovf = 1'b1;
                end else begin
                    n_tl = m_tl[i] + 32'd1;
                end
            end
            n_tcon = m_tcon[i];
            if (w && o == 3'd2) begin
                n_tcon[1:0] = wdata[1:0];
                if (wdata[2]) n_tcon[2] = 1'b0;
            end
            if (ovf && m_tcon[i][1]) n_tcon[2] = 1'b1;
            if (w && o == 3'd0) m_th[i] = wdata;
            if (w && o == 3'd3) m_led[i] = wdata[7:0];
            if (w && o == 3'd4) m_digi[i] = wdata[11:0];
            m_sys[i] = (w && o == 3'd5) ? 32'd0 : m_sys[i] + 32'd1;
            m_tl[i] = n_tl;
            m_tcon[i] = n_tcon;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] off, input logic [31:0] data);
        addr = Base + {27'd0, off};
        wdata = data;
        mem_read = 1'b0;
        mem_write = 1'b1;
        step();
        mem_write = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; addr = Base; wdata = '0; mem_read = 1'b0; mem_write = 1'b0;
        model_reset();
        repeat (3) step();
        checks++;
        if ({led1, digi1, irq1, led4, digi4, irq4} !== 42'd0) begin
            $display("FAIL reset_outputs: got led=%h digi=%h irq=%b want 0", led1, digi1, irq1);
            failures++;
        end
        for (int o = 0; o < 6; o++) begin
            addr = Base + 32'(o * 4);
            #1;
            checks++;
            if (rdata1 !== 32'd0 || rdata4 !== 32'd0 || hit1 !== 1'b1) begin
                $display("FAIL reset_read off=%0h: got %h/%h hit=%b want 0 hit=1",
                         o * 4, rdata1, rdata4, hit1);
                failures++;
            end
        end
        reset = 1'b1;
        step();
        for (int o = 0; o < 6; o++) begin
            addr = Base + 32'(o * 4);
            #1;
            checks++;
            if (rdata1 !== m_rdata(0, addr) || (o < 5 && rdata1 !== 32'd0)) begin
                $display("FAIL post_reset_read off=%0h: got %h want %h",
                         o * 4, rdata1, m_rdata(0, addr));
                failures++;
            end
        end
    endtask

    task automatic test_led_write();
        addr = Base + 32'hC; wdata = 32'h1A5; mem_read = 1'b1; mem_write = 1'b1;
        #1;
        checks++;
        if (rdata1 !== 32'd0) begin
            $display("FAIL led_write_cycle_read: got %h want 00000000", rdata1);
            failures++;
        end
        step();
        mem_write = 1'b0;
        #1;
        checks++;
        if (led1 !== 8'hA5 || led4 !== 8'hA5 || rdata1 !== 32'hA5) begin
            $display("FAIL led_after_write: got led=%h rdata=%h want led=a5 rdata=a5", led1, rdata1);
            failures++;
        end
    endtask

    task automatic test_overflow();
        wr(5'h00, 32'hFFFF_FFF0);
        wr(5'h04, 32'hFFFF_FFFE);
        wr(5'h08, 32'h3);
        addr = Base + 32'h4;
        #1;
        checks++;
        if (rdata1 !== 32'hFFFF_FFFE) begin
            $display("FAIL ovf_tl0: got %h want fffffffe", rdata1);
            failures++;
        end
        step();
        checks++;
        if (rdata1 !== 32'hFFFF_FFFF || irq1 !== 1'b0) begin
            $display("FAIL ovf_tl1: got tl=%h irq=%b want ffffffff irq=0", rdata1, irq1);
            failures++;
        end
        step();
        checks++;
        if (rdata1 !== 32'hFFFF_FFF0 || irq1 !== 1'b1) begin
            $display("FAIL ovf_reload: got tl=%h irq=%b want fffffff0 irq=1", rdata1, irq1);
            failures++;
        end
        wr(5'h08, 32'h7);
        addr = Base + 32'h4;
        #1;
        checks++;
        if (irq1 !== 1'b0 || rdata1 !== 32'hFFFF_FFF1) begin
            $display("FAIL irq_clear: got irq=%b tl=%h want irq=0 tl=fffffff1", irq1, rdata1);
            failures++;
        end
        step();
        checks++;
        if (rdata1 !== 32'hFFFF_FFF2 || rdata4 !== m_rdata(1, addr) || irq4 !== m_irq(1)) begin
            $display("FAIL ovf_continue: got tl=%h tl4=%h irq4=%b want fffffff2 %h %b",
                     rdata1, rdata4, irq4, m_rdata(1, addr), m_irq(1));
            failures++;
        end
    endtask

    task automatic test_set_beats_clear();
        wr(5'h08, 32'h4);
        wr(5'h04, 32'hFFFF_FFFE);
        wr(5'h08, 32'h3);
        step();
        // This cycle TL=ffffffff with a tick pending: overflow collides with the clear.
        wr(5'h08, 32'h7);
        addr = Base + 32'h4;
        #1;
        checks++;
        if (irq1 !== 1'b1 || rdata1 !== 32'hFFFF_FFF0) begin
            $display("FAIL set_beats_clear: got irq=%b tl=%h want irq=1 tl=fffffff0", irq1, rdata1);
            failures++;
        end
        step();
        checks++;
        if (irq1 !== 1'b1 || irq4 !== m_irq(1)) begin
            $display("FAIL irq_held: got irq=%b irq4=%b want 1 %b", irq1, irq4, m_irq(1));
            failures++;
        end
        wr(5'h08, 32'h4);
        checks++;
        if (irq1 !== 1'b0) begin
            $display("FAIL irq_clear2: got %b want 0", irq1);
            failures++;
        end
    endtask

    task automatic test_prescaler();
        logic [7:0] led_before;
        logic [31:0] junk;
        wr(5'h08, 32'h4);
        wr(5'h04, 32'h0);
        wr(5'h08, 32'h1);
        addr = Base + 32'h4;
        repeat (3) step();
        checks++;
        if (rdata4 !== 32'd0) begin
            $display("FAIL presc_3: got %h want 0", rdata4);
            failures++;
        end
        step();
        checks++;
        if (rdata4 !== 32'd1) begin
            $display("FAIL presc_4: got %h want 1", rdata4);
            failures++;
        end
        repeat (4) step();
        checks++;
        if (rdata4 !== 32'd2 || rdata1 !== m_rdata(0, addr)) begin
            $display("FAIL presc_8: got %h/%h want 2/%h", rdata4, rdata1, m_rdata(0, addr));
            failures++;
        end
        led_before = led1;
        junk = $urandom;
        addr = Base + 32'h20; wdata = junk; mem_write = 1'b1;
        #1;
        checks++;
        if (hit1 !== 1'b0 || hit4 !== 1'b0 || rdata1 !== 32'd0) begin
            $display("FAIL decode_miss: got hit=%b/%b rdata=%h want 0/0/0", hit1, hit4, rdata1);
            failures++;
        end
        step();
        mem_write = 1'b0;
        for (int o = 0; o < 5; o++) begin
            addr = Base + 32'(o * 4);
            #1;
            checks++;
            if (rdata1 !== m_rdata(0, addr) || rdata4 !== m_rdata(1, addr) || led1 !== led_before) begin
                $display("FAIL decode_nochange off=%0h: got %h/%h want %h/%h", o * 4,
                         rdata1, rdata4, m_rdata(0, addr), m_rdata(1, addr));
                failures++;
            end
        end
    endtask

    task automatic test_systick();
        logic [31:0] v1;
        logic [31:0] v2;
        addr = Base + 32'h14;
        #1;
`ifdef MMIO_SYSTICK_EN
        v1 = rdata1;
        repeat (5) step();
        v2 = rdata1;
        checks++;
        if (v2 - v1 !== 32'd5 || v2 !== m_rdata(0, addr)) begin
            $display("FAIL systick_delta: got %h->%h want delta 5 final %h", v1, v2, m_rdata(0, addr));
            failures++;
        end
        wr(5'h14, $urandom);
        addr = Base + 32'h14;
        #1;
        checks++;
        if (rdata1 !== 32'd0 || rdata4 !== 32'd0) begin
            $display("FAIL systick_clear: got %h/%h want 0", rdata1, rdata4);
            failures++;
        end
`else
        v1 = rdata1;
        wr(5'h14, $urandom);
        addr = Base + 32'h14;
        #1;
        v2 = rdata1;
        checks++;
        if (v1 !== 32'd0 || v2 !== 32'd0) begin
            $display("FAIL systick_absent: got %h,%h want 0", v1, v2);
            failures++;
        end
`endif
    endtask

    task automatic test_random();
        int off;
        for (int n = 0; n < 400; n++) begin
            off = int'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) addr = $urandom;
            else addr = Base + 32'(off * 4) + 32'($urandom_range(0, 3));
            if (off == 1 && $urandom_range(0, 1) == 1) wdata = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            else wdata = $urandom;
            mem_write = ($urandom_range(0, 2) == 0);
            mem_read = $urandom_range(0, 1) == 1;
            #1;
            checks++;
            if (hit1 !== m_hit(addr) || rdata1 !== m_rdata(0, addr) || rdata4 !== m_rdata(1, addr)) begin
                $display("FAIL rand_read n=%0d addr=%h: got hit=%b %h/%h want hit=%b %h/%h", n, addr,
                         hit1, rdata1, rdata4, m_hit(addr), m_rdata(0, addr), m_rdata(1, addr));
                failures++;
            end
            step();
            checks++;
            if ({led1, digi1, irq1, led4, digi4, irq4} !==
                {m_led[0], m_digi[0], m_irq(0), m_led[1], m_digi[1], m_irq(1)}) begin
                $display("FAIL rand_outputs n=%0d: got %h %h %b / %h %h %b want %h %h %b / %h %h %b", n,
                         led1, digi1, irq1, led4, digi4, irq4, m_led[0], m_digi[0], m_irq(0),
                         m_led[1], m_digi[1], m_irq(1));
                failures++;
            end
        end
        mem_write = 1'b0;
    endtask

    task automatic test_reset_midcount();
        wr(5'h00, 32'h5);
        wr(5'h04, 32'hFFFF_FFF0);
        wr(5'h0C, 32'h3C);
        wr(5'h08, 32'h3);
        addr = Base + 32'h4;
        repeat (3) step();
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if (led1 !== 8'd0 || irq1 !== 1'b0 || rdata1 !== 32'd0 || rdata4 !== 32'd0) begin
            $display("FAIL reset_midcount: got led=%h irq=%b tl=%h/%h want 0", led1, irq1, rdata1, rdata4);
            failures++;
        end
        step();
        reset = 1'b1;
        step();
        checks++;
        if (rdata1 !== 32'd0 || rdata4 !== 32'd0) begin
            $display("FAIL reset_release_tl: got %h/%h want 0 (timer disabled)", rdata1, rdata4);
            failures++;
        end
    endtask

    initial begin
        test_reset();
        test_led_write();
        test_overflow();
        test_set_beats_clear();
        test_prescaler();
        test_systick();
        test_random();
        test_reset_midcount();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

endmodule

// File: doc/mmio_timer_periph.md
# mmio_timer_periph

Memory-mapped peripheral responder for the pipelined CPU's data-memory bus. It decodes the MEM-stage address, write data and read/write strobes. It owns the timer, LED, seven-segment and systick registers, and returns read data in the same cycle. It sits beside the data RAM and drives the board `led`/`digi` pins plus a timer interrupt line.

## Interface
- `BASE_ADDR`, 32'h4000_0000: window base; window is BASE_ADDR .. BASE_ADDR+0x1F.
- `TICK_DIV`, 1: timer prescale; TL advances once per TICK_DIV enabled cycles (legal range 1..65535).
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low.
- `addr`  in  32  byte address from the MEM stage; bits [1:0] ignored.
- `wdata`  in  32  store data.
- `mem_read`  in  1  load strobe.
- `mem_write`  in  1  store strobe.
- `rdata`  out  32  load data, combinational.
- `hit`  out  1  addr is inside the window; the system mux selects `rdata` over RAM when high.
- `led`  out  8  LED register.
- `digi`  out  12  seven-segment register.
- `irq`  out  1  timer interrupt, level.

## Operation
- Register map (offset from BASE_ADDR):
  - 0x00 TH: reload value, R/W.
  - 0x04 TL: counter, R/W.
  - 0x08 TCON: [0] enable, [1] irq enable, [2] irq status. Bits [1:0] are written directly; writing 1 to bit 2 clears it, writing 0 leaves it; other bits read 0.
  - 0x0C LED [7:0], R/W.
  - 0x10 DIGI [11:0], R/W.
  - 0x14 SYSTICK: read-only free-running count; any write clears it to 0.
  - 0x18, 0x1C: read 0, writes ignored.
- Decode:
  - `hit = (addr[31:5] == BASE_ADDR[31:5])`.
  - Outside the window, `rdata` = 0 and writes are ignored.
  - `rdata` is valid whenever `hit`, regardless of `mem_read`.
  - `mem_read` and `mem_write` both high: the write is performed and `rdata` still shows the pre-write value.
- Prescaler: a 16-bit counter runs only while TCON[0]=1. It produces a tick when it equals TICK_DIV-1, then returns to 0. Clearing TCON[0] zeroes it.
- Timer, on a tick:
  - TL != 32'hFFFF_FFFF: TL <= TL+1.
  - Otherwise: TL <= TH, and TCON[2] <= 1 if TCON[1]=1.
- `irq = TCON[1] & TCON[2]`.
- Collision priorities:
  - CPU write to TL in the same cycle as a tick: the write wins and the tick is discarded.
  - CPU write to TH during an overflow cycle: TL reloads the old TH.
  - Write-1-to-clear of TCON[2] in the same cycle as an overflow setting it: the set wins.
- SYSTICK: increments every cycle and wraps 0xFFFF_FFFF -> 0. A write clears it to 0 at that edge; the next cycle reads 0.

## Timing
- Reads have zero latency: `rdata` reflects register state in the current cycle.
- Writes take effect at the rising edge where `mem_write && hit`; a read in the following cycle sees the new value.
- `led`, `digi` and `irq` are registered or derived only from registers; they change on the edge after the write or event.
- `irq` rises on the edge that performs the overflow reload.
- Reset (asserted low, at any time, including mid-count): all registers, the prescaler and SYSTICK go to 0. Consequently `led`=0, `digi`=0, `irq`=0. `rdata` = 0 for all offsets; `hit` stays combinational.
- No internal state survives reset. The first tick after reset and enable occurs TICK_DIV cycles after TCON[0] is written to 1.

## Configuration
- `MMIO_SYSTICK_EN` defined: the SYSTICK register and its 32-bit counter are compiled in as described.
- Undefined: no counter logic exists; offset 0x14 reads 0 and writes are ignored, identical to 0x18.

## Test plan
- Reset behaviour: hold reset low for 3 cycles, release -> `led`=0, `digi`=0, `irq`=0, reads of 0x00–0x14 return 0.
- LED write with simultaneous read: write 0x4000_000C = 0x1A5 with `mem_read`=1 -> `rdata`=0 in the write cycle; `led`=8'hA5 and a read returns 0xA5 on the next cycle.
- Overflow and interrupt clear (TICK_DIV=1): TH=0xFFFF_FFF0, TL=0xFFFF_FFFE, TCON=3 -> TL=0xFFFF_FFFF after 1 cycle, TL=0xFFFF_FFF0 and `irq`=1 after 2. Write TCON=0x7 -> `irq`=0 next cycle, TL continues incrementing.
- Set-beats-clear collision: schedule the write of TCON=0x7 on the exact overflow cycle -> `irq` stays 1.
- Prescaler and address decode (TICK_DIV=4): TL=0, TCON=1 -> TL=1 after 4 cycles, 2 after 8. Write to 0x4000_0020 -> `hit`=0 and no register changes.
- SYSTICK, built with `MMIO_SYSTICK_EN`: read 0x14 twice, 5 cycles apart -> difference is 5. Write 0x14 -> next read is 0. Built without the macro -> read 0x14 returns 0.
